alu_cond_unit: RTL and testbench

- Consumer end of the ALU status outputs (n, z, c, v).
- Captures the ALU's NZCV flags into an architectural status register on a write strobe.
- Answers condition-code queries (4-bit ARM-style cond) over a valid/ready handshake, returning a registered pass/fail result tagged to the query.
- Sits between the ALU result/flag outputs and the branch/predication logic.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_cond_unit_skid.sv | 39 +++
 rtl/alu_cond_unit.sv | 62 ++++++
 tb/tb_alu_cond_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: condition-code enum, NZCV flag indices and the condition evaluator.
package alu_pkg;
  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  function automatic logic cond_eval(input cond_e cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    cond_eval = 1'b0;
    case (cond)
      EQ: cond_eval = z;
      NE: cond_eval = !z;
      CS: cond_eval = c;
      CC: cond_eval = !c;
      MI: cond_eval = n;
      PL: cond_eval = !n;
      VS: cond_eval = v;
      VC: cond_eval = !v;
      HI: cond_eval = c && !z;
      LS: cond_eval = !c || z;
      GE: cond_eval = n == v;
      LT: cond_eval = n != v;
      GT: cond_eval = !z && (n == v);
      LE: cond_eval = z || (n != v);
      AL: cond_eval = 1'b1;
      NV: cond_eval = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_cond_unit_skid.sv
// alu_cond_skid: 2-entry valid/ready buffer (output register + skid entry), ready registered.
module alu_cond_skid #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_out_v, r_sk_v;
  logic [W-1:0] r_out_d, r_sk_d;
  logic         w_acc, w_load;
  assign o_ready = !r_sk_v;
  assign w_acc   = i_valid && !r_sk_v;
  assign w_load  = !r_out_v || i_ready;
  assign o_valid = r_out_v;
  assign o_data  = r_out_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v <= 1'b0;
      r_out_d <= '0;
      r_sk_v  <= 1'b0;
      r_sk_d  <= '0;
    end else if (w_load) begin
      // A full skid entry always blocks acceptance, so it drains first.
      r_out_v <= r_sk_v || w_acc;
      r_sk_v  <= 1'b0;
      if (r_sk_v) r_out_d <= r_sk_d;
      else if (w_acc) r_out_d <= i_data;
    end else if (w_acc) begin
      r_sk_v <= 1'b1;
      r_sk_d <= i_data;
    end
  end
endmodule

// File: rtl/alu_cond_unit.sv
// alu_cond_unit: NZCV status register plus condition-code query unit with registered results.
// Optional ALU_COND_SHADOW_EN adds a shadow flag register with save/restore.
module alu_cond_unit
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic             n_in,
  input  logic             z_in,
  input  logic             c_in,
  input  logic             v_in,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [3:0]       q_cond,
  input  logic [TAG_W-1:0] q_tag,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             r_pass,
  output logic [TAG_W-1:0] r_tag,
  output logic [3:0]       flags
`ifdef ALU_COND_SHADOW_EN
  ,
  input  logic             flag_save,
  input  logic             flag_restore
`endif
);
  logic [3:0]     r_flags;
  logic [3:0]     w_next;
  logic [TAG_W:0] w_req, w_res;
`ifdef ALU_COND_SHADOW_EN
  logic [3:0] r_shadow;
  assign w_next = flag_we ? {n_in, z_in, c_in, v_in} : flag_restore ? r_shadow : r_flags;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_shadow <= '0;
    else if (!flag_we && !flag_restore && flag_save) r_shadow <= r_flags;
  end
`else
  assign w_next = flag_we ? {n_in, z_in, c_in, v_in} : r_flags;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_flags <= '0;
    else r_flags <= w_next;
  end
  // Evaluating against the next flag value gives write-before-read bypass.
  assign w_req = {cond_eval(cond_e'(q_cond), w_next), q_tag};
  alu_cond_skid #(.W(TAG_W + 1)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(q_valid),
    .o_ready(q_ready),
    .i_data (w_req),
    .o_valid(r_valid),
    .i_ready(r_ready),
    .o_data (w_res)
  );
  assign r_pass = w_res[TAG_W];
  assign r_tag  = w_res[TAG_W-1:0];
  assign flags  = r_flags;
endmodule

// File: tb/tb_alu_cond_unit.sv
// tb_alu_cond_unit: directed + random stimulus against a queue-based reference model.
module tb_alu_cond_unit;
  localparam int TAG_W = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic flag_we = 1'b0, n_in = 1'b0, z_in = 1'b0, c_in = 1'b0, v_in = 1'b0;
  logic q_valid = 1'b0, r_ready = 1'b1;
  logic [3:0] q_cond = '0;
  logic [TAG_W-1:0] q_tag = '0;
  logic q_ready, r_valid, r_pass;
  logic [TAG_W-1:0] r_tag;
  logic [3:0] flags;
`ifdef ALU_COND_SHADOW_EN
  logic flag_save = 1'b0, flag_restore = 1'b0;
`endif
  int checks = 0, errors = 0;
  logic [3:0] m_flags = '0, m_shadow = '0;
  logic [TAG_W:0] m_q[$];
  logic last_acc;

  always #5 clk = ~clk;

  alu_cond_unit #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
    .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .q_valid(q_valid), .q_ready(q_ready), .q_cond(q_cond), .q_tag(q_tag),
    .r_valid(r_valid), .r_ready(r_ready), .r_pass(r_pass), .r_tag(r_tag),
    .flags(flags)
`ifdef ALU_COND_SHADOW_EN
    , .flag_save(flag_save), .flag_restore(flag_restore)
`endif
  );

  // Odd codes are the complement of the preceding even code (AL/NV included).
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic [7:0] base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    base = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
    return base[cond[3:1]] ^ cond[0];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic m_ready;
    logic [3:0] nf;
    m_ready = m_q.size() < 2;
    chk("q_ready", {7'd0, q_ready}, {7'd0, m_ready});
    nf = flag_we ? {n_in, z_in, c_in, v_in} : m_flags;
`ifdef ALU_COND_SHADOW_EN
    if (!flag_we && flag_restore) nf = m_shadow;
`endif
    last_acc = q_valid && m_ready;
    @(posedge clk);
    if (m_q.size() > 0 && r_ready) void'(m_q.pop_front());
    if (last_acc) m_q.push_back({ref_cond(q_cond, nf), q_tag});
`ifdef ALU_COND_SHADOW_EN
    if (!flag_we && !flag_restore && flag_save) m_shadow = m_flags;
`endif
    m_flags = nf;
    #1;
    chk("flags", {4'd0, flags}, {4'd0, m_flags});
    chk("r_valid", {7'd0, r_valid}, {7'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("r_pass", {7'd0, r_pass}, {7'd0, m_q[0][TAG_W]});
      chk("r_tag", {4'd0, r_tag}, {4'd0, m_q[0][TAG_W-1:0]});
    end
  endtask

  task automatic send(input logic [3:0] cond, input logic [TAG_W-1:0] tag);
    q_valid = 1'b1; q_cond = cond; q_tag = tag;
    tick();
    q_valid = 1'b0; flag_we = 1'b0;
  endtask

  task automatic wflags(input logic [3:0] f);
    flag_we = 1'b1; {n_in, z_in, c_in, v_in} = f;
    tick();
    flag_we = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_flags", {4'd0, flags}, 8'h00);
    chk("rst_r_valid", {7'd0, r_valid}, 8'h00);
    chk("rst_r_pass", {7'd0, r_pass}, 8'h00);
    chk("rst_r_tag", {4'd0, r_tag}, 8'h00);
    #8 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_q_ready", {7'd0, q_ready}, 8'h01);
    send(4'h0, 4'd1);
    chk("eq_pass", {7'd0, r_pass}, 8'h00);
    chk("eq_tag", {4'd0, r_tag}, 8'h01);
    tick();
    wflags(4'b0100);
    send(4'h0, 4'd2); send(4'h1, 4'd3); send(4'h9, 4'd4); tick();
    flag_we = 1'b1; {n_in, z_in, c_in, v_in} = 4'b1000;
    send(4'h4, 4'd5);
    chk("bypass_pass", {7'd0, r_pass}, 8'h01);
    chk("bypass_tag", {4'd0, r_tag}, 8'h05);
    send(4'h5, 4'd6); tick();
    r_ready = 1'b0;
    send(4'hE, 4'd1); send(4'hE, 4'd2);
    q_valid = 1'b1; q_cond = 4'hE; q_tag = 4'd3;
    tick(); tick();
    chk("stall_tag", {4'd0, r_tag}, 8'h01);
    r_ready = 1'b1;
    for (int i = 0; i < 6 && !last_acc; i++) tick();
    chk("tag3_accepted", {7'd0, last_acc}, 8'h01);
    q_valid = 1'b0;
    tick(); tick(); tick();
    wflags(4'b0011);
    send(4'hA, 4'd1); send(4'hB, 4'd2); send(4'hC, 4'd3);
    send(4'h8, 4'd4); send(4'hE, 4'd5); send(4'hF, 4'd6);
    wflags(4'b1001);
    send(4'hA, 4'd7); tick();
    r_ready = 1'b0;
    send(4'hE, 4'd8); send(4'hE, 4'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_r_valid", {7'd0, r_valid}, 8'h00);
    chk("arst_q_ready", {7'd0, q_ready}, 8'h01);
    chk("arst_flags", {4'd0, flags}, 8'h00);
    m_q.delete(); m_flags = '0; m_shadow = '0;
    r_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tick();
`ifdef ALU_COND_SHADOW_EN
    wflags(4'b1010);
    flag_save = 1'b1; tick(); flag_save = 1'b0;
    wflags(4'b0101);
    flag_restore = 1'b1;
    send(4'h4, 4'd7);
    flag_restore = 1'b0;
    chk("restore_flags", {4'd0, flags}, 8'h0A);
    chk("restore_bypass", {7'd0, r_pass}, 8'h01);
    tick();
`endif
    for (int i = 0; i < 500; i++) begin
      flag_we = ($urandom_range(0, 3) == 0);
      {n_in, z_in, c_in, v_in} = 4'($urandom);
      q_valid = ($urandom_range(0, 3) != 0);
      q_cond = 4'($urandom);
      q_tag = 4'($urandom);
      r_ready = ($urandom_range(0, 2) != 0);
`ifdef ALU_COND_SHADOW_EN
      flag_save = ($urandom_range(0, 4) == 0);
      flag_restore = ($urandom_range(0, 4) == 0);
`endif
      tick();
    end
    q_valid = 1'b0; flag_we = 1'b0; r_ready = 1'b1;
`ifdef ALU_COND_SHADOW_EN
    flag_save = 1'b0; flag_restore = 1'b0;
`endif
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
